tank_sprite_server: RTL and testbench

- Pixel-data responder for the tank overlay stage in the VGA pipeline.
- Accepts a 12-bit sprite address every clock and returns the 12-bit RGB texel one clock later, which matches the overlay stage's one-cycle-delayed compositing.
- Sprite storage is double-buffered (2 × 64×64 × 12-bit). New sprite images stream in through a valid/ready port into the back bank, and the banks swap only at a frame boundary, so a sprite never tears mid-frame.

---
 rtl/tank_sprite_server.sv | 94 +++++++++
 tb/tb_tank_sprite_server.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/tank_sprite_server.sv
// Double-buffered 64x64 sprite texel server with a one-cycle registered read and a frame-synchronous bank swap.
// Optional macro SPRITE_MIRROR_EN adds a mirror_x input that flips the read column.
module tank_sprite_server #(
    parameter int                SIDE_W      = 6,
    parameter int                DATA_W      = 12,
    parameter logic [DATA_W-1:0] TRANSPARENT = 12'hFFF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [2*SIDE_W-1:0]   pixel_addr,
`ifdef SPRITE_MIRROR_EN
    input  logic                  mirror_x,
`endif
    output logic [DATA_W-1:0]     rgb_pixel,
    input  logic                  vsync_in,
    input  logic                  wr_valid,
    input  logic [DATA_W-1:0]     wr_data,
    output logic                  wr_ready,
    output logic                  front_bank,
    output logic                  front_valid,
    output logic                  swap_pulse
);

    localparam int ADDR_W = 2 * SIDE_W;
    localparam int DEPTH  = 1 << ADDR_W;

    typedef enum logic [1:0] {LOAD, FULL, SWAP} state_t;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   wptr;
    logic [ADDR_W-1:0]   rd_addr;
    logic                vs_d;
    logic                rise;
    logic                wr_fire;
    logic [DATA_W-1:0]   rd_q_p1;
    logic                vld_p1;

    logic [DATA_W-1:0]   mem [0:2*DEPTH-1];

    assign rise       = vsync_in & ~vs_d;
    assign wr_fire    = wr_valid & wr_ready;
    assign swap_pulse = (state == SWAP);

    always_comb begin
        rd_addr = pixel_addr;
`ifdef SPRITE_MIRROR_EN
        if (mirror_x) rd_addr[SIDE_W-1:0] = ~pixel_addr[SIDE_W-1:0];
`endif
    end

    always_comb begin
        state_nxt = state;
        case (state)
            LOAD:    if (wr_fire && (&wptr)) state_nxt = FULL;
            FULL:    if (rise) state_nxt = SWAP;
            SWAP:    state_nxt = LOAD;
            default: state_nxt = LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= LOAD;
            vs_d        <= 1'b0;
            wptr        <= '0;
            wr_ready    <= 1'b0;
            front_bank  <= 1'b0;
            front_valid <= 1'b0;
            vld_p1      <= 1'b0;
        end else begin
            state    <= state_nxt;
            vs_d     <= vsync_in;
            // Registered so it drops the cycle after the last accept and stays low during reset.
            wr_ready <= (state_nxt == LOAD);
            vld_p1   <= front_valid;
            if (state == SWAP) begin
                front_bank  <= ~front_bank;
                front_valid <= 1'b1;
                wptr        <= '0;
            end else if (wr_fire) begin
                wptr <= wptr + ADDR_W'(1);
            end
        end
    end

    // Stage p0 -> p1: RAM write into the back bank, registered read from the front bank.
    always_ff @(posedge clk) begin
        if (wr_fire) mem[{~front_bank, wptr}] <= wr_data;
        rd_q_p1 <= mem[{front_bank, rd_addr}];
    end

    assign rgb_pixel = vld_p1 ? rd_q_p1 : TRANSPARENT;

endmodule

// File: tb/tb_tank_sprite_server.sv
// Randomized scoreboard bench for tank_sprite_server against an image-level reference model.
module tb_tank_sprite_server;

    logic        clk;
    logic        rst;
    logic [11:0] pixel_addr;
    logic [11:0] rgb_pixel;
    logic        vsync_in;
    logic        wr_valid;
    logic [11:0] wr_data;
    logic        wr_ready;
    logic        front_bank;
    logic        front_valid;
    logic        swap_pulse;
`ifdef SPRITE_MIRROR_EN
    logic        mirror_x;
`endif

    tank_sprite_server dut (
        .clk         (clk),
        .rst         (rst),
        .pixel_addr  (pixel_addr),
`ifdef SPRITE_MIRROR_EN
        .mirror_x    (mirror_x),
`endif
        .rgb_pixel   (rgb_pixel),
        .vsync_in    (vsync_in),
        .wr_valid    (wr_valid),
        .wr_data     (wr_data),
        .wr_ready    (wr_ready),
        .front_bank  (front_bank),
        .front_valid (front_valid),
        .swap_pulse  (swap_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] rgb;
        logic        rdy;
        logic        fb;
        logic        fv;
        logic        sp;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;

    // Reference model: two whole images, a count of texels written to the back image,
    // and whether the coming cycle is the swap cycle.
    logic [11:0] img [2][4096];
    logic        m_fb, m_fv, m_rdy, m_swap, m_vs;
    int          m_cnt;
    int          swap_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_fb = 1'b0; m_fv = 1'b0; m_rdy = 1'b0; m_swap = 1'b0; m_vs = 1'b0; m_cnt = 0;
    endtask

    task automatic step(input logic [11:0] a, input logic mx, input logic wv,
                        input logic [11:0] wd, input logic vs);
        exp_t        e;
        logic        mx_eff;
        logic [11:0] ra;
        logic        rise, acc, swap_now, full_before;
        @(negedge clk);
        pixel_addr = a;
        wr_valid   = wv;
        wr_data    = wd;
        vsync_in   = vs;
`ifdef SPRITE_MIRROR_EN
        mirror_x   = mx;
        mx_eff     = mx;
`else
        mx_eff     = mx & 1'b0;
`endif
        ra = mx_eff ? {a[11:6], ~a[5:0]} : a;
        e.rgb = m_fv ? img[m_fb][ra] : 12'hFFF;
        rise        = vs && !m_vs;
        m_vs        = vs;
        acc         = wv && m_rdy;
        swap_now    = m_swap;
        full_before = (m_cnt == 4096);
        if (acc) begin
            img[m_fb ^ 1'b1][m_cnt] = wd;
            m_cnt++;
        end
        m_swap = !swap_now && full_before && rise;
        if (swap_now) begin
            m_fb  = ~m_fb;
            m_fv  = 1'b1;
            m_cnt = 0;
            swap_cnt++;
        end
        m_rdy = !m_swap && (m_cnt < 4096);
        e.rdy = m_rdy;
        e.fb  = m_fb;
        e.fv  = m_fv;
        e.sp  = m_swap;
        q.push_back(e);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("rgb_pixel",   32'(rgb_pixel),   32'(e.rgb));
                chk("wr_ready",    32'(wr_ready),    32'(e.rdy));
                chk("front_bank",  32'(front_bank),  32'(e.fb));
                chk("front_valid", 32'(front_valid), 32'(e.fv));
                chk("swap_pulse",  32'(swap_pulse),  32'(e.sp));
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rgb"},   32'(rgb_pixel),   32'h0FFF);
        chk({tag, "_rdy"},   32'(wr_ready),    32'h0);
        chk({tag, "_fb"},    32'(front_bank),  32'h0);
        chk({tag, "_fv"},    32'(front_valid), 32'h0);
        chk({tag, "_swap"},  32'(swap_pulse),  32'h0);
    endtask

    // dmode: 0 data=address, 1 constant 0F0, 2 random.
    // vmode: 0 rise at wptr=100 then periodic, 1 rise on the final write, 2 periodic.
    task automatic load_phase(input int dmode, input int vmode, input bit rnd_valid);
        int          guard = 0;
        int          start = swap_cnt;
        int          vhold = 0;
        logic        wv, vs, mx;
        logic [11:0] wd;
        while (swap_cnt == start && guard < 20000) begin
            wv = rnd_valid ? ($urandom_range(0, 3) != 0) : 1'b1;
            case (dmode)
                0:       wd = 12'(m_cnt);
                1:       wd = 12'h0F0;
                default: wd = 12'($urandom);
            endcase
            case (vmode)
                0: vs = (m_cnt >= 100 && m_cnt < 104) || (m_cnt == 4096 && (guard % 64) < 4);
                1: begin
                    if (m_cnt == 4095 && m_rdy && wv) vhold = 6;
                    vs = (vhold > 0) || (m_cnt == 4096 && (guard % 64) < 4);
                    if (vhold > 0) vhold--;
                end
                default: vs = (guard % 300) < 5;
            endcase
            mx = 1'($urandom_range(0, 1));
            step(12'($urandom), mx, wv, wd, vs);
            guard++;
        end
        if (swap_cnt == start) begin
            tests++;
            fails++;
            $display("FAIL swap_timeout: got no swap expected a swap within 20000 cycles");
        end
    endtask

    initial begin
        rst        = 1'b0;
        pixel_addr = 12'h000;
        vsync_in   = 1'b0;
        wr_valid   = 1'b0;
        wr_data    = 12'h000;
`ifdef SPRITE_MIRROR_EN
        mirror_x   = 1'b0;
`endif
        model_reset();
        #3;
        check_reset_outputs("por");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        repeat (6) step(12'h000, 1'b0, 1'b0, 12'h000, 1'b0);

        load_phase(0, 0, 1'b0);
        step(12'h041, 1'b0, 1'b0, 12'h000, 1'b0);
        @(posedge clk);
        #2;
        chk("read_041", 32'(rgb_pixel), 32'h041);
`ifdef SPRITE_MIRROR_EN
        step(12'h041, 1'b1, 1'b0, 12'h000, 1'b0);
        @(posedge clk);
        #2;
        chk("mirror_041", 32'(rgb_pixel), 32'h07E);
`endif

        load_phase(1, 2, 1'b1);
        load_phase(2, 1, 1'b1);

        for (int i = 0; i < 500; i++)
            step(12'($urandom), 1'($urandom_range(0, 1)), 1'b1, 12'($urandom), 1'b0);
        @(negedge clk);
        #2;
        rst      = 1'b0;
        wr_valid = 1'b0;
        vsync_in = 1'b0;
        #1;
        check_reset_outputs("midload");
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        model_reset();

        repeat (4) step(12'($urandom), 1'b0, 1'b0, 12'h000, 1'b0);
        load_phase(2, 2, 1'b1);
        repeat (8) step(12'($urandom), 1'($urandom_range(0, 1)), 1'b0, 12'h000, 1'b0);

        @(posedge clk);
        #2;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
